// File: rtl/modinv_engine.sv
// modinv_engine: modular inversion / division by binary extended Euclid, streamed out word by word
module modinv_engine #(
  parameter int N = 256,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         load_a,
  input  logic         load_b,
  input  logic         load_p,
  input  logic         mode,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] result_out,
  output logic         out_valid,
  input  logic         out_ready
);
  localparam int K  = N / W;
  localparam int CW = $clog2(4 * N + 3);
  localparam int IW = $clog2(K + 1);
  typedef enum logic [1:0] {IDLE, CHECK, ITER, OUT} state_t;
  state_t         state;
  logic [N-1:0]   a, b, p, u, v, x1, x2, res, shin;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  idx;
  logic           inv;
  // halve modulo m: odd values get m added first so the sum is even and stays below m after the shift
  function automatic logic [N-1:0] half(input logic [N-1:0] x, input logic [N-1:0] m);
    logic [N:0] s;
    s = {1'b0, x} + (x[0] ? {1'b0, m} : '0);
    return s[N:1];
  endfunction
  function automatic logic [N-1:0] sub(input logic [N-1:0] x, input logic [N-1:0] y, input logic [N-1:0] m);
    logic [N:0] d;
    d = {1'b0, x} - {1'b0, y};
    return d[N] ? d[N-1:0] + m : d[N-1:0];
  endfunction
  assign shin = N'(din) << (N - W);
  assign result_out = res[W-1:0];
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      {busy, done, err, out_valid, inv} <= '0;
      {a, b, p, u, v, x1, x2, res} <= '0;
      cnt <= '0;
      idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_a) a <= (a >> W) | shin;
          if (load_b) b <= (b >> W) | shin;
          if (load_p) p <= (p >> W) | shin;
          if (start) begin
            state <= CHECK;
            busy  <= 1'b1;
            err   <= 1'b0;
            inv   <= mode;
          end
        end
        CHECK: begin
          if (!p[0] || p < N'(3) || a == '0 || a >= p || (!inv && b >= p)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            u     <= a;
            v     <= p;
            x1    <= inv ? N'(1) : b;
            x2    <= '0;
            cnt   <= '0;
            state <= ITER;
          end
        end
        ITER: begin
          if (u == N'(1) || v == N'(1)) begin
            res       <= (u == N'(1)) ? x1 : x2;
            idx       <= '0;
            out_valid <= 1'b1;
            done      <= 1'b1;
            state     <= OUT;
          end else if (u == '0 || v == '0 || cnt == CW'(4 * N + 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
            if (!u[0]) begin
              u  <= u >> 1;
              x1 <= half(x1, p);
            end else if (!v[0]) begin
              v  <= v >> 1;
              x2 <= half(x2, p);
            end else if (u >= v) begin
              u  <= u - v;
              x1 <= sub(x1, x2, p);
            end else begin
              v  <= v - u;
              x2 <= sub(x2, x1, p);
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            res <= res >> W;
            idx <= idx + IW'(1);
            if (idx == IW'(K - 1)) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_modinv_engine.sv
// tb_modinv_engine: directed checks of modinv_engine at N=32/W=8 and N=256/W=32
module tb_modinv_engine;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;

  logic [7:0]  s_din = '0;
  logic        s_la = 0, s_lb = 0, s_lp = 0, s_mode = 0, s_start = 0, s_ready = 0;
  logic        s_busy, s_done, s_err, s_ov;
  logic [7:0]  s_res;
  modinv_engine #(.N(32), .W(8)) dut_s (
    .clk(clk), .rst(rst), .din(s_din), .load_a(s_la), .load_b(s_lb), .load_p(s_lp),
    .mode(s_mode), .start(s_start), .busy(s_busy), .done(s_done), .err(s_err),
    .result_out(s_res), .out_valid(s_ov), .out_ready(s_ready));

  logic [31:0] b_din = '0;
  logic        b_la = 0, b_lb = 0, b_lp = 0, b_mode = 0, b_start = 0, b_ready = 0;
  logic        b_busy, b_done, b_err, b_ov;
  logic [31:0] b_res;
  modinv_engine #(.N(256), .W(32)) dut_b (
    .clk(clk), .rst(rst), .din(b_din), .load_a(b_la), .load_b(b_lb), .load_p(b_lp),
    .mode(b_mode), .start(b_start), .busy(b_busy), .done(b_done), .err(b_err),
    .result_out(b_res), .out_valid(b_ov), .out_ready(b_ready));

  // sel bit0 = a, bit1 = b, bit2 = p
  task automatic load_s(input logic [2:0] sel, input logic [31:0] val);
    for (int k = 0; k < 4; k++) begin
      s_din = val[8*k +: 8];
      {s_lp, s_lb, s_la} = sel;
      @(negedge clk);
    end
    {s_lp, s_lb, s_la} = '0;
  endtask

  task automatic run_s(input logic m, input int limit, output logic e, output int lat, output logic [31:0] r);
    s_mode = m;
    s_start = 1;
    @(negedge clk);
    s_start = 0;
    lat = 1;
    while (!s_done && lat < limit) begin
      @(negedge clk);
      lat++;
    end
    e = s_err;
    r = '0;
    if (s_done && !s_err) begin
      s_ready = 1;
      for (int k = 0; k < 4; k++) begin
        r[8*k +: 8] = s_res;
        @(negedge clk);
      end
      s_ready = 0;
    end
  endtask

  task automatic load_b256(input logic [2:0] sel, input logic [255:0] val);
    for (int k = 0; k < 8; k++) begin
      b_din = val[32*k +: 32];
      {b_lp, b_lb, b_la} = sel;
      @(negedge clk);
    end
    {b_lp, b_lb, b_la} = '0;
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (3) @(negedge clk);
    if ({s_busy, s_done, s_err, s_ov} !== 4'b0) begin fails++; $display("FAIL reset_flags got=%b want=0000", {s_busy, s_done, s_err, s_ov}); end
    tests++;
    if (s_res !== 8'h00) begin fails++; $display("FAIL reset_result got=%h want=00", s_res); end
    tests++;
    if ({b_busy, b_done, b_err, b_ov, b_res} !== '0) begin fails++; $display("FAIL reset_big got=%b/%h want=0", {b_busy, b_done, b_err, b_ov}, b_res); end
    tests++;
    rst = 1;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    logic [31:0] vp[7] = '{32'd11, 32'd11, 32'd3, 32'd13, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'hFFFFFFFB};
    logic [31:0] va[7] = '{32'd5, 32'd5, 32'd2, 32'd1, 32'd3, 32'd2, 32'hFFFFFFFA};
    logic [31:0] vb[7] = '{32'd0, 32'd3, 32'd0, 32'd0, 32'd0, 32'h88664422, 32'd0};
    logic        vm[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] ve[7] = '{32'd9, 32'd5, 32'd2, 32'd1, 32'h55555554, 32'h44332211, 32'hFFFFFFFA};
    logic e;
    int lat;
    logic [31:0] r;
    for (int i = 0; i < 7; i++) begin
      load_s(3'b100, vp[i]);
      load_s(3'b001, va[i]);
      if (!vm[i]) load_s(3'b010, vb[i]);
      run_s(vm[i], 200, e, lat, r);
      if (e !== 1'b0 || lat > 132) begin fails++; $display("FAIL vec%0d_status err=%b lat=%0d want err=0 lat<=132", i, e, lat); end
      tests++;
      if (r !== ve[i]) begin fails++; $display("FAIL vec%0d_result got=%h want=%h", i, r, ve[i]); end
      tests++;
    end
    // operands retained: a = p-1 and b from vector 5, so b/a = p - b
    run_s(1'b0, 200, e, lat, r);
    if (e !== 1'b0 || r !== 32'h7799BBD9) begin fails++; $display("FAIL recompute got err=%b r=%h want err=0 r=7799bbd9", e, r); end
    tests++;
    if (s_busy !== 1'b0 || s_ov !== 1'b0) begin fails++; $display("FAIL idle_after_out busy=%b ov=%b want 0 0", s_busy, s_ov); end
    tests++;
  endtask

  task automatic test_errors();
    logic [31:0] ep[5] = '{32'd15, 32'd12, 32'd11, 32'd11, 32'd1};
    logic [31:0] ea[5] = '{32'd5, 32'd5, 32'd11, 32'd5, 32'd1};
    logic [31:0] eb[5] = '{32'd0, 32'd0, 32'd0, 32'd11, 32'd0};
    logic        em[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic e;
    int lat;
    logic [31:0] r;
    logic ov;
    for (int i = 0; i < 5; i++) begin
      load_s(3'b111, 32'd0);
      load_s(3'b100, ep[i]);
      load_s(3'b001, ea[i]);
      load_s(3'b010, eb[i]);
      run_s(em[i], 200, e, lat, r);
      ov = s_ov;
      if (e !== 1'b1 || s_done !== 1'b1) begin fails++; $display("FAIL err%0d_flag err=%b done=%b want 1 1", i, e, s_done); end
      tests++;
      if ((i == 0 && lat > 132) || (i != 0 && lat != 2)) begin fails++; $display("FAIL err%0d_latency got=%0d want %s", i, lat, i == 0 ? "<=132" : "2"); end
      tests++;
      @(negedge clk);
      if (ov !== 1'b0 || s_ov !== 1'b0 || s_busy !== 1'b0) begin fails++; $display("FAIL err%0d_no_output ov=%b,%b busy=%b want 0", i, ov, s_ov, s_busy); end
      tests++;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_w[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int lat;
    load_s(3'b100, 32'hFFFFFFFB);
    load_s(3'b001, 32'd2);
    load_s(3'b010, 32'h88664422);
    s_mode = 0;
    s_start = 1;
    @(negedge clk);
    s_start = 0;
    lat = 1;
    while (!s_done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (s_ov !== 1'b1 || s_res !== exp_w[0]) begin fails++; $display("FAIL bp_word0 ov=%b res=%h want 1 11", s_ov, s_res); end
    tests++;
    s_ready = 1;
    @(negedge clk);
    s_ready = 0;
    for (int c = 0; c < 3; c++) begin
      if (s_ov !== 1'b1 || s_res !== exp_w[1] || s_busy !== 1'b1) begin fails++; $display("FAIL bp_stall%0d ov=%b res=%h busy=%b want 1 22 1", c, s_ov, s_res, s_busy); end
      tests++;
      @(negedge clk);
    end
    s_ready = 1;
    for (int k = 1; k < 4; k++) begin
      if (s_ov !== 1'b1 || s_res !== exp_w[k]) begin fails++; $display("FAIL bp_word%0d ov=%b res=%h want 1 %h", k, s_ov, s_res, exp_w[k]); end
      tests++;
      @(negedge clk);
    end
    s_ready = 0;
    if (s_ov !== 1'b0 || s_busy !== 1'b0) begin fails++; $display("FAIL bp_end ov=%b busy=%b want 0 0", s_ov, s_busy); end
    tests++;
  endtask

  task automatic test_reset_abort();
    logic e;
    int lat;
    logic [31:0] r;
    int seen_done;
    load_s(3'b100, 32'hFFFFFFFB);
    load_s(3'b001, 32'd3);
    s_mode = 1;
    s_start = 1;
    @(negedge clk);
    s_start = 0;
    if (s_busy !== 1'b1) begin fails++; $display("FAIL busy_rise got=%b want 1", s_busy); end
    tests++;
    repeat (5) @(negedge clk);
    rst = 0;
    @(negedge clk);
    rst = 1;
    if ({s_busy, s_done, s_err, s_ov, s_res} !== 12'h000) begin fails++; $display("FAIL abort_outputs got=%b/%h want 0", {s_busy, s_done, s_err, s_ov}, s_res); end
    tests++;
    seen_done = 0;
    repeat (150) begin
      @(negedge clk);
      if (s_done || s_ov) seen_done++;
    end
    if (seen_done != 0) begin fails++; $display("FAIL abort_silent got=%0d want 0 done/valid cycles", seen_done); end
    tests++;
    run_s(1'b1, 200, e, lat, r);
    if (e !== 1'b1 || lat != 2) begin fails++; $display("FAIL zero_operands err=%b lat=%0d want 1 2", e, lat); end
    tests++;
  endtask

  task automatic test_busy_ignore();
    logic e;
    int lat;
    logic [31:0] r;
    load_s(3'b100, 32'd11);
    s_la = 1;
    s_din = 8'hAA;
    @(negedge clk);
    s_la = 0;
    load_s(3'b001, 32'd5);
    s_mode = 1;
    s_start = 1;
    @(negedge clk);
    s_la = 1;
    s_din = 8'h07;
    @(negedge clk);
    s_la = 0;
    s_mode = 0;
    lat = 2;
    while (!s_done && lat < 200) begin
      @(negedge clk);
      lat++;
      s_start = 0;
    end
    s_start = 0;
    if (s_err !== 1'b0 || s_ov !== 1'b1 || s_res !== 8'h09) begin fails++; $display("FAIL busy_ignore err=%b ov=%b res=%h want 0 1 09", s_err, s_ov, s_res); end
    tests++;
    s_ready = 1;
    repeat (4) @(negedge clk);
    s_ready = 0;
    repeat (3) begin
      if (s_busy !== 1'b0) begin fails++; $display("FAIL no_queued_start busy=%b want 0", s_busy); end
      tests++;
      @(negedge clk);
    end
    run_s(1'b1, 200, e, lat, r);
    if (e !== 1'b0 || r !== 32'd9) begin fails++; $display("FAIL nine_word_load err=%b r=%h want 0 00000009", e, r); end
    tests++;
  endtask

  task automatic test_big();
    logic [255:0] p = 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
    logic [255:0] a = 256'h32C4AE2C_1F198119_5F990446_6A39C994_8FE30BBF_F2660BE1_715A4589_334C74C7;
    logic [255:0] b = 256'hBC3736A2_F4F6779C_59BDCEE3_6B692153_D0A9877C_C62A4740_02DF32E5_2139F0A0;
    logic [255:0] r;
    logic [511:0] prod;
    logic [511:0] want;
    int lat;
    load_b256(3'b100, p);
    load_b256(3'b001, a);
    load_b256(3'b010, b);
    for (int m = 0; m < 2; m++) begin
      b_mode = (m == 1);
      b_start = 1;
      @(negedge clk);
      b_start = 0;
      lat = 1;
      while (!b_done && lat < 1100) begin
        @(negedge clk);
        lat++;
      end
      if (b_done !== 1'b1 || b_err !== 1'b0 || lat > 1028) begin fails++; $display("FAIL big_m%0d_status done=%b err=%b lat=%0d want 1 0 <=1028", m, b_done, b_err, lat); end
      tests++;
      r = '0;
      b_ready = 1;
      for (int k = 0; k < 8 && b_ov; k++) begin
        r[32*k +: 32] = b_res;
        @(negedge clk);
      end
      b_ready = 0;
      prod = ({256'b0, r} * {256'b0, a}) % {256'b0, p};
      want = (m == 1) ? 512'd1 : {256'b0, b};
      if (r >= p || prod !== want) begin fails++; $display("FAIL big_m%0d_result r=%h r*a%%p=%h want %h", m, r, prod[255:0], want[255:0]); end
      tests++;
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_errors();
    test_backpressure();
    test_reset_abort();
    test_busy_ignore();
    test_big();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
